// File: rtl/fetch_unit.sv
// Instruction-fetch datapath: program counter, one-entry prefetch buffer and
// instruction register, fed from instruction memory over a req/ack handshake.
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 12,
    parameter int OPC_W   = 4
) (
    input  logic               clk,
    input  logic               CLB,
    input  logic               LoadIR,
    input  logic               IncPC,
    input  logic               LoadPC,
    input  logic               SelPC,
    input  logic [PC_W-1:0]    RegVal,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [OPC_W-1:0]   Opcode,
    output logic [7:0]         Imm,
    output logic [PC_W-1:0]    PC,
    output logic               IRValid,
    output logic               Stall,
    output logic               Halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic [PC_W-1:0]    tag_r, tag_s;
    logic [INSTR_W-1:0] buf_r, buf_s;
    logic [INSTR_W-1:0] ir_r, ir_s;
    logic               ir_valid_r, ir_valid_s;
    logic               stall_r, stall_s;
    logic               halted_r, halted_s;
    logic               active_s;
    logic               pc_change_s;

    // Next-state, PC update and IR load; HALT freezes everything but reset.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        tag_s       = tag_r;
        buf_s       = buf_r;
        ir_s        = ir_r;
        ir_valid_s  = ir_valid_r;
        stall_s     = 1'b0;
        halted_s    = halted_r;
        active_s    = (state_r != HALT);
        pc_change_s = active_s & (LoadPC | IncPC);

        // LoadPC reads the IR as it stands, before any same-cycle LoadIR.
        if (active_s && LoadPC) begin
            pc_s = SelPC ? RegVal : ir_r[PC_W-1:0];
        end else if (active_s && IncPC) begin
            pc_s = pc_r + PC_W'(1);
        end else begin
            pc_s = pc_r;
        end

        case (state_r)
            FETCH: begin
                tag_s = pc_r;
                if (mem_ack) begin
                    buf_s   = mem_data;
                    state_s = pc_change_s ? FETCH : FULL;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    buf_s   = mem_data;
                    state_s = ((tag_r == pc_r) && !pc_change_s) ? FULL : FETCH;
                end else begin
                    state_s = WAIT;
                end
            end
            FULL: begin
                state_s = pc_change_s ? FETCH : FULL;
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s = FETCH;
            end
        endcase

        // The buffer is only valid in FULL, so a halt never leaves a request in flight.
        if (active_s && LoadIR) begin
            if (state_r == FULL) begin
                ir_s       = buf_r;
                ir_valid_s = 1'b1;
                if (buf_r[INSTR_W-1 -: OPC_W] == {OPC_W{1'b1}}) begin
                    state_s  = HALT;
                    halted_s = 1'b1;
                end else begin
                    halted_s = halted_r;
                end
            end else begin
                ir_s       = {INSTR_W{1'b0}};
                ir_valid_s = 1'b0;
                stall_s    = 1'b1;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (CLB) begin
            state_r    <= FETCH;
            pc_r       <= {PC_W{1'b0}};
            tag_r      <= {PC_W{1'b0}};
            buf_r      <= {INSTR_W{1'b0}};
            ir_r       <= {INSTR_W{1'b0}};
            ir_valid_r <= 1'b0;
            stall_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            tag_r      <= tag_s;
            buf_r      <= buf_s;
            ir_r       <= ir_s;
            ir_valid_r <= ir_valid_s;
            stall_r    <= stall_s;
            halted_r   <= halted_s;
        end
    end

    // Request is masked while reset is held so nothing is issued during reset.
    assign mem_req  = ~CLB & ((state_r == FETCH) | (state_r == WAIT));
    assign mem_addr = (state_r == WAIT) ? tag_r : pc_r;
    assign Opcode   = ir_r[INSTR_W-1 -: OPC_W];
    assign Imm      = ir_r[7:0];
    assign PC       = pc_r;
    assign IRValid  = ir_valid_r;
    assign Stall    = stall_r;
    assign Halted   = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        CLB, LoadIR, IncPC, LoadPC, SelPC;
    logic [7:0]  RegVal;
    logic        mem_req, mem_ack;
    logic [7:0]  mem_addr;
    logic [11:0] mem_data;
    logic [3:0]  Opcode;
    logic [7:0]  Imm, PC;
    logic        IRValid, Stall, Halted;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
        .SelPC(SelPC), .RegVal(RegVal), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .Opcode(Opcode), .Imm(Imm),
        .PC(PC), .IRValid(IRValid), .Stall(Stall), .Halted(Halted)
    );

    always #5 clk = ~clk;

    task automatic ack_once(input logic [11:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        @(negedge clk);
        mem_ack  = 1'b0;
    endtask

    task automatic test_reset();
        CLB = 1'b1; LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0;
        RegVal = 8'h00; mem_ack = 1'b0; mem_data = 12'h000;
        @(negedge clk);
        @(negedge clk);
        total++; if (PC !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=%h", PC, 8'h00); end
        total++; if (Opcode !== 4'h0) begin bad++; $display("FAIL rst_opc got=%h exp=%h", Opcode, 4'h0); end
        total++; if (IRValid !== 1'b0) begin bad++; $display("FAIL rst_irvalid got=%b exp=0", IRValid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        total++; if ({Stall, Halted} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {Stall, Halted}); end
        CLB = 1'b0;
        #1;
    endtask

    task automatic test_fetch_basic();
        for (int i = 0; i < 3; i++) begin
            total++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin bad++; $display("FAIL hold_req%0d got=%b/%h exp=1/00", i, mem_req, mem_addr); end
            if (i == 2) begin
                mem_ack = 1'b1; mem_data = 12'h105;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", mem_req); end
        LoadIR = 1'b1;
        @(negedge clk);
        LoadIR = 1'b0;
        total++; if ({Opcode, Imm, IRValid} !== {4'h1, 8'h05, 1'b1}) begin bad++; $display("FAIL ld_ir got=%h/%h/%b exp=1/05/1", Opcode, Imm, IRValid); end
        IncPC = 1'b1;
        @(negedge clk);
        IncPC = 1'b0;
        total++; if ({PC, mem_req, mem_addr} !== {8'h01, 1'b1, 8'h01}) begin bad++; $display("FAIL inc_pc got=%h/%b/%h exp=01/1/01", PC, mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        LoadPC = 1'b1; SelPC = 1'b1; RegVal = 8'hFF;
        @(negedge clk);
        LoadPC = 1'b0;
        total++; if ({PC, mem_addr} !== {8'hFF, 8'h01}) begin bad++; $display("FAIL jmp_ff got=%h/%h exp=ff/01", PC, mem_addr); end
        ack_once(12'h111);
        total++; if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin bad++; $display("FAIL refetch_ff got=%b/%h exp=1/ff", mem_req, mem_addr); end
        ack_once(12'h2AA);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_ff got=%b exp=0", mem_req); end
        IncPC = 1'b1;
        @(negedge clk);
        IncPC = 1'b0;
        total++; if ({PC, mem_req, mem_addr} !== {8'h00, 1'b1, 8'h00}) begin bad++; $display("FAIL wrap got=%h/%b/%h exp=00/1/00", PC, mem_req, mem_addr); end
    endtask

    task automatic test_loadpc();
        ack_once(12'h73A);
        LoadIR = 1'b1; LoadPC = 1'b1; SelPC = 1'b1; RegVal = 8'h05;
        @(negedge clk);
        LoadIR = 1'b0; LoadPC = 1'b0;
        total++; if ({Opcode, Imm, IRValid} !== {4'h7, 8'h3A, 1'b1}) begin bad++; $display("FAIL ir_73a got=%h/%h/%b exp=7/3a/1", Opcode, Imm, IRValid); end
        total++; if ({PC, mem_req, mem_addr} !== {8'h05, 1'b1, 8'h05}) begin bad++; $display("FAIL pc_05 got=%h/%b/%h exp=05/1/05", PC, mem_req, mem_addr); end
        @(negedge clk);
        LoadPC = 1'b1; SelPC = 1'b0;
        @(negedge clk);
        LoadPC = 1'b0;
        total++; if ({PC, mem_req, mem_addr} !== {8'h3A, 1'b1, 8'h05}) begin bad++; $display("FAIL jmp_imm got=%h/%b/%h exp=3a/1/05", PC, mem_req, mem_addr); end
        ack_once(12'h111);
        total++; if ({mem_req, mem_addr, Opcode} !== {1'b1, 8'h3A, 4'h7}) begin bad++; $display("FAIL discard got=%b/%h/%h exp=1/3a/7", mem_req, mem_addr, Opcode); end
        LoadPC = 1'b1; SelPC = 1'b1; RegVal = 8'hC4;
        @(negedge clk);
        LoadPC = 1'b0;
        total++; if ({PC, mem_addr} !== {8'hC4, 8'h3A}) begin bad++; $display("FAIL jmp_reg got=%h/%h exp=c4/3a", PC, mem_addr); end
        ack_once(12'h222);
        total++; if ({mem_req, mem_addr} !== {1'b1, 8'hC4}) begin bad++; $display("FAIL refetch_c4 got=%b/%h exp=1/c4", mem_req, mem_addr); end
    endtask

    task automatic test_stall();
        LoadIR = 1'b1;
        @(negedge clk);
        LoadIR = 1'b0;
        total++; if ({Opcode, Imm, IRValid, Stall} !== {4'h0, 8'h00, 1'b0, 1'b1}) begin bad++; $display("FAIL stall got=%h/%h/%b/%b exp=0/00/0/1", Opcode, Imm, IRValid, Stall); end
        @(negedge clk);
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL stall_clr got=%b exp=0", Stall); end
    endtask

    task automatic test_halt();
        ack_once(12'hF00);
        LoadIR = 1'b1;
        @(negedge clk);
        LoadIR = 1'b0;
        total++; if ({Halted, Opcode, PC} !== {1'b1, 4'hF, 8'hC4}) begin bad++; $display("FAIL halt got=%b/%h/%h exp=1/f/c4", Halted, Opcode, PC); end
        for (int i = 0; i < 2; i++) begin
            IncPC = 1'b1; LoadPC = (i == 1); LoadIR = 1'b1;
            @(negedge clk);
            total++; if ({PC, mem_req, Opcode} !== {8'hC4, 1'b0, 4'hF}) begin bad++; $display("FAIL halt_hold%0d got=%h/%b/%h exp=c4/0/f", i, PC, mem_req, Opcode); end
        end
        IncPC = 1'b0; LoadPC = 1'b0; LoadIR = 1'b0;
        ack_once(12'h123);
        total++; if ({Halted, mem_req, Opcode} !== {1'b1, 1'b0, 4'hF}) begin bad++; $display("FAIL halt_ack got=%b/%b/%h exp=1/0/f", Halted, mem_req, Opcode); end
        CLB = 1'b1;
        @(negedge clk);
        total++; if ({Halted, PC, Opcode, IRValid, mem_req} !== {1'b0, 8'h00, 4'h0, 1'b0, 1'b0}) begin bad++; $display("FAIL halt_rst got=%b/%h/%h/%b/%b exp=0/00/0/0/0", Halted, PC, Opcode, IRValid, mem_req); end
        CLB = 1'b0;
        #1;
        total++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin bad++; $display("FAIL post_rst got=%b/%h exp=1/00", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_wrap();
        test_loadpc();
        test_stall();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
